// File: rtl/instr_fetch_unit_pkg.sv
// rv_pkg: shared fetch-path types and constants
package rv_pkg;
    localparam int XLEN = 64;
    localparam int ILEN = 32;
    typedef logic [XLEN-1:0] xlen_t;
    typedef struct packed {
        logic [ILEN-1:0] instr;
        xlen_t           pc;
    } fetch_entry_t;
    localparam xlen_t RESET_VECTOR_DEFAULT = '0;
    typedef enum logic {RUN, DRAIN} fetch_state_e;
endpackage

// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: imem request/response, decode handshake and redirect signals
interface instr_fetch_unit_if #(
    parameter int DEPTH = 4
);
    import rv_pkg::*;
    logic                   imem_req_valid;
    logic                   imem_req_ready;
    xlen_t                  imem_req_addr;
    logic                   imem_rsp_valid;
    logic [ILEN-1:0]        imem_rsp_data;
    logic                   instr_valid;
    logic                   instr_ready;
    logic [ILEN-1:0]        instr;
    xlen_t                  instr_pc;
    xlen_t                  instr_pc_plus4;
    logic                   redirect_valid;
    xlen_t                  redirect_pc;
    logic [$clog2(DEPTH):0] outstanding;
    modport master (
        output imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_pc_plus4, outstanding,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
    );
    modport slave (
        input  imem_req_valid, imem_req_addr, instr_valid, instr, instr_pc, instr_pc_plus4, outstanding,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, instr_ready, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush (flush beats push), used for fetched words and PC tags
module fetch_fifo
    import rv_pkg::*;
#(
    parameter type T     = fetch_entry_t,
    parameter int  DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  T                       data_i,
    output T                       data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW:0] cnt_t;
    T              mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    cnt_t          count_q;
    logic          pop;
    assign pop     = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q];
    assign count_o = count_q;
    assign full_o  = count_q == cnt_t'(DEPTH);
    assign empty_o = count_q == '0;
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            assert (!(push_i && full_o && !pop));
            if (push_i) begin
                mem_q[wr_q] <= data_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + cnt_t'(push_i) - cnt_t'(pop);
        end
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: credit-limited sequential fetch with word buffer and redirect discard
// Requests are capped so every outstanding response always has a FIFO slot waiting for it.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int    DEPTH        = 4,
    parameter xlen_t RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    typedef logic [CW-1:0] cnt_t;
    typedef logic [CW:0]   sum_t;
    fetch_state_e state_q, state_d;
    xlen_t        pc_q, pc_d, tag_pc;
    cnt_t         out_q, out_d, disc_q, disc_d, fifo_cnt, tag_cnt;
    fetch_entry_t head;
    logic         accept, rsp, drop, push, pop;
    logic         fifo_full, fifo_empty, tag_full, tag_empty;
    assign bus.imem_req_valid = !reset && !bus.redirect_valid &&
                                (sum_t'(out_q) + sum_t'(fifo_cnt) < sum_t'(DEPTH));
    assign bus.imem_req_addr  = pc_q;
    assign accept             = bus.imem_req_valid && bus.imem_req_ready;
    assign rsp                = bus.imem_rsp_valid;
    // Responses to requests issued before the latest redirect are stale
    assign drop               = bus.redirect_valid || state_q == DRAIN;
    assign push               = rsp && !drop;
    assign pop                = bus.instr_valid && bus.instr_ready;
    assign bus.instr_valid    = !reset && !fifo_empty;
    assign bus.instr          = head.instr;
    assign bus.instr_pc       = head.pc;
    assign bus.instr_pc_plus4 = head.pc + xlen_t'(4);
    assign bus.outstanding    = out_q;
    always_comb begin
        out_d   = out_q + cnt_t'(accept) - cnt_t'(rsp);
        disc_d  = bus.redirect_valid ? out_q - cnt_t'(rsp) : disc_q - cnt_t'(rsp && state_q == DRAIN);
        pc_d    = bus.redirect_valid ? bus.redirect_pc & ~xlen_t'(3) : accept ? pc_q + xlen_t'(4) : pc_q;
        state_d = disc_d != '0 ? DRAIN : RUN;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VECTOR;
            out_q   <= '0;
            disc_q  <= '0;
            state_q <= RUN;
        end else begin
            assert (sum_t'(out_q) + sum_t'(fifo_cnt) <= sum_t'(DEPTH));
            assert (disc_q <= out_q);
            assert (tag_cnt == out_q - disc_q);
            assert (!(push && (fifo_full || tag_empty)) && !(accept && tag_full));
            pc_q    <= pc_d;
            out_q   <= out_d;
            disc_q  <= disc_d;
            state_q <= state_d;
        end
    end
    fetch_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_buf (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (bus.redirect_valid),
        .data_i  ('{instr: bus.imem_rsp_data, pc: tag_pc}),
        .data_o  (head),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );
    fetch_fifo #(.T(xlen_t), .DEPTH(DEPTH)) u_tag (
        .clk     (clk),
        .reset   (reset),
        .push_i  (accept),
        .pop_i   (push),
        .flush_i (bus.redirect_valid),
        .data_i  (pc_q),
        .data_o  (tag_pc),
        .count_o (tag_cnt),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of fetch ordering, credit cap, redirect discard and reset
module tb_instr_fetch_unit;
    import rv_pkg::*;
    logic  clk = 1'b0;
    logic  reset = 1'b1;
    int    total = 0;
    int    bad = 0;
    int    cyc_n = 0;
    int    lat = 1;
    xlen_t pq_addr[$];
    int    pq_due[$];
    xlen_t iss[$];
    xlen_t pops[$];
    initial forever #5 clk = ~clk;
    instr_fetch_unit_if #(.DEPTH(4)) bus ();
    instr_fetch_unit #(.DEPTH(4), .RESET_VECTOR(64'h0)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );
    function automatic logic [31:0] word(input xlen_t a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction
    task automatic chk(input string tag, input xlen_t obs, input xlen_t exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    // Memory model: records accepted requests, returns them in order after lat cycles
    task automatic cyc();
        @(negedge clk);
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            pq_addr.push_back(bus.imem_req_addr);
            pq_due.push_back(cyc_n + lat);
            iss.push_back(bus.imem_req_addr);
        end
        if (bus.instr_valid && bus.instr_ready) pops.push_back(bus.instr_pc);
        @(posedge clk);
        #1;
        cyc_n++;
        if (pq_due.size() > 0 && pq_due[0] <= cyc_n) begin
            bus.imem_rsp_valid = 1'b1;
            bus.imem_rsp_data  = word(pq_addr.pop_front());
            void'(pq_due.pop_front());
        end else begin
            bus.imem_rsp_valid = 1'b0;
            bus.imem_rsp_data  = '0;
        end
        #1;
    endtask
    task automatic clear_model();
        pq_addr.delete();
        pq_due.delete();
        iss.delete();
        pops.delete();
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
    endtask
    task automatic do_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;
        clear_model();
        #1;
    endtask
    initial begin
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.instr_ready    = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        // 1: reset state, then streaming at one instruction per cycle
        cyc();
        cyc();
        chk("rst_req_valid", xlen_t'(bus.imem_req_valid), 0);
        chk("rst_instr_valid", xlen_t'(bus.instr_valid), 0);
        chk("rst_outstanding", xlen_t'(bus.outstanding), 0);
        reset = 1'b0;
        clear_model();
        #1;
        chk("t1_first_req_valid", xlen_t'(bus.imem_req_valid), 1);
        chk("t1_addr0", bus.imem_req_addr, 64'h0);
        cyc();
        chk("t1_addr4", bus.imem_req_addr, 64'h4);
        chk("t1_outstanding1", xlen_t'(bus.outstanding), 1);
        chk("t1_not_valid_yet", xlen_t'(bus.instr_valid), 0);
        cyc();
        chk("t1_valid", xlen_t'(bus.instr_valid), 1);
        chk("t1_pc0", bus.instr_pc, 64'h0);
        chk("t1_instr0", xlen_t'(bus.instr), xlen_t'(word(64'h0)));
        chk("t1_pc_plus4", bus.instr_pc_plus4, 64'h4);
        chk("t1_addr8", bus.imem_req_addr, 64'h8);
        cyc();
        chk("t1_pc4", bus.instr_pc, 64'h4);
        cyc();
        chk("t1_pc8", bus.instr_pc, 64'h8);
        chk("t1_valid_steady", xlen_t'(bus.instr_valid), 1);
        // 2: decode stalled, credit cap of DEPTH, then release
        bus.instr_ready = 1'b0;
        lat = 1;
        do_reset();
        repeat (6) cyc();
        chk("t2_req_capped", xlen_t'(bus.imem_req_valid), 0);
        chk("t2_issued_count", xlen_t'(iss.size()), 4);
        chk("t2_iss1", iss[1], 64'h4);
        chk("t2_iss3", iss[3], 64'hC);
        chk("t2_outstanding0", xlen_t'(bus.outstanding), 0);
        chk("t2_head0", bus.instr_pc, 64'h0);
        bus.instr_ready = 1'b1;
        #1;
        cyc();
        chk("t2_pop0", pops[0], 64'h0);
        chk("t2_head4", bus.instr_pc, 64'h4);
        chk("t2_req_after_pop", xlen_t'(bus.imem_req_valid), 1);
        chk("t2_addr10", bus.imem_req_addr, 64'h10);
        cyc();
        chk("t2_head8", bus.instr_pc, 64'h8);
        chk("t2_addr14", bus.imem_req_addr, 64'h14);
        cyc();
        chk("t2_headC", bus.instr_pc, 64'hC);
        // 3: redirect with two requests in flight at 3-cycle latency
        lat = 3;
        do_reset();
        cyc();
        cyc();
        chk("t3_outstanding2", xlen_t'(bus.outstanding), 2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h103;
        #1;
        chk("t3_no_req_on_redirect", xlen_t'(bus.imem_req_valid), 0);
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t3_req_valid", xlen_t'(bus.imem_req_valid), 1);
        chk("t3_addr100", bus.imem_req_addr, 64'h100);
        chk("t3_empty_c3", xlen_t'(bus.instr_valid), 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t3_no_stale", xlen_t'(bus.instr_valid), 0);
        end
        cyc();
        chk("t3_valid", xlen_t'(bus.instr_valid), 1);
        chk("t3_pc100", bus.instr_pc, 64'h100);
        chk("t3_instr100", xlen_t'(bus.instr), xlen_t'(word(64'h100)));
        // 4: redirect coinciding with a response and a pop
        lat = 2;
        do_reset();
        repeat (3) cyc();
        chk("t4_head0", bus.instr_pc, 64'h0);
        chk("t4_outstanding2", xlen_t'(bus.outstanding), 2);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h400;
        #1;
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t4_pop_done", xlen_t'(pops.size()), 1);
        chk("t4_popped_pc0", pops[0], 64'h0);
        chk("t4_flushed", xlen_t'(bus.instr_valid), 0);
        chk("t4_outstanding1", xlen_t'(bus.outstanding), 1);
        chk("t4_addr400", bus.imem_req_addr, 64'h400);
        cyc();
        chk("t4_stale_dropped", xlen_t'(bus.instr_valid), 0);
        chk("t4_outstanding_c5", xlen_t'(bus.outstanding), 1);
        cyc();
        chk("t4_empty_c6", xlen_t'(bus.instr_valid), 0);
        cyc();
        chk("t4_valid400", xlen_t'(bus.instr_valid), 1);
        chk("t4_pc400", bus.instr_pc, 64'h400);
        // 5: back-to-back redirects while draining; last target wins
        lat = 3;
        do_reset();
        cyc();
        cyc();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h100;
        #1;
        cyc();
        bus.redirect_pc = 64'h200;
        #1;
        chk("t5_no_req_200", xlen_t'(bus.imem_req_valid), 0);
        cyc();
        bus.redirect_pc = 64'h300;
        #1;
        chk("t5_no_req_300", xlen_t'(bus.imem_req_valid), 0);
        cyc();
        bus.redirect_valid = 1'b0;
        #1;
        chk("t5_req_valid", xlen_t'(bus.imem_req_valid), 1);
        chk("t5_addr300", bus.imem_req_addr, 64'h300);
        chk("t5_outstanding0", xlen_t'(bus.outstanding), 0);
        repeat (3) cyc();
        chk("t5_not_valid_c8", xlen_t'(bus.instr_valid), 0);
        cyc();
        chk("t5_valid", xlen_t'(bus.instr_valid), 1);
        chk("t5_pc300", bus.instr_pc, 64'h300);
        chk("t5_iss2", iss[2], 64'h300);
        // 6: reset mid-operation with requests in flight and buffered words
        lat = 3;
        bus.instr_ready = 1'b0;
        do_reset();
        repeat (4) cyc();
        chk("t6_outstanding3", xlen_t'(bus.outstanding), 3);
        chk("t6_buffered", xlen_t'(bus.instr_valid), 1);
        chk("t6_capped", xlen_t'(bus.imem_req_valid), 0);
        reset = 1'b1;
        #1;
        cyc();
        chk("t6_rst_instr_valid", xlen_t'(bus.instr_valid), 0);
        chk("t6_rst_outstanding", xlen_t'(bus.outstanding), 0);
        chk("t6_rst_req_valid", xlen_t'(bus.imem_req_valid), 0);
        cyc();
        reset = 1'b0;
        clear_model();
        #1;
        chk("t6_req_valid", xlen_t'(bus.imem_req_valid), 1);
        chk("t6_addr_reset_vector", bus.imem_req_addr, 64'h0);
        chk("t6_outstanding0", xlen_t'(bus.outstanding), 0);
        chk("t6_instr_valid0", xlen_t'(bus.instr_valid), 0);
        cyc();
        chk("t6_outstanding1", xlen_t'(bus.outstanding), 1);
        chk("t6_addr4", bus.imem_req_addr, 64'h4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
